conv_window_sequencer: RTL

- Controls the image buffer / convolution datapath for one 4x4 tile of 4-bit pixels.
- Accepts a tile from upstream via valid/ready and pulses the buffer's load enable.
- Steps through the four 3x3 windows. Each window gets a start pulse to the convolution unit and waits for calc_done.
- Reports tile completion; a per-window timeout raises a sticky error.

---
 rtl/conv_window_sequencer_pkg.sv | 24 ++
 rtl/conv_window_sequencer_wait_timer.sv | 28 ++
 rtl/conv_window_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and defaults for the 4x4-tile convolution window sequencer.
// Pixel/tile/window shapes match the image buffer and convolution unit.
package conv_pkg;

  localparam int DEF_NUM_WIN = 4;
  localparam int DEF_SEL_W   = $clog2(DEF_NUM_WIN);
  localparam int DEF_TIMEOUT = 32;
  localparam int DEF_CNT_W   = 8;

  typedef logic [3:0] pixel_t;
  typedef pixel_t [3:0][3:0] tile_t;
  typedef pixel_t [2:0][2:0] win_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    NEXT,
    DONE,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/conv_window_sequencer_wait_timer.sv
// Clearable up-counter; expired is high while count sits at TIMEOUT-1.
// Holds at expiry so a late enable never wraps back to zero.
module wait_timer #(
  parameter int TIMEOUT = 32,
  parameter int W       = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences tile load and four 3x3 window convolutions; tile_ready decoded, other outputs registered.
// Handshake to tile_done is 14 cycles with one-cycle calc; upstream is stalled outside IDLE.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_WIN = DEF_NUM_WIN,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tile_valid,
  output logic             tile_ready,
  output logic             load_enable,
  output logic             conv_start,
  input  logic             calc_done,
  output logic [SEL_W-1:0] window_sel,
  output logic             tile_done,
  output logic [CNT_W-1:0] tile_count,
  input  logic             abort,
  output logic             err,
  input  logic             clear_err
);

  seq_state_t       state;
  seq_state_t       next_state;
  logic             timer_expired;
  logic             last_win;
  logic             load_enable_d;
  logic             conv_start_d;
  logic             tile_done_d;
  logic             err_d;
  logic [SEL_W-1:0] window_sel_d;
  logic [CNT_W-1:0] tile_count_d;

  assign tile_ready = (state == IDLE);
  assign last_win   = (window_sel == SEL_W'(NUM_WIN - 1));

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (state != WAIT),
    .en      (state == WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort wins over everything except the ERROR state, which only clear_err leaves
  always_comb begin
    next_state = state;
    if (abort && state != ERROR) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (tile_valid) next_state = LOAD;
        LOAD:    next_state = START;
        START:   next_state = WAIT;
        WAIT: begin
          if (calc_done)          next_state = NEXT;
          else if (timer_expired) next_state = ERROR;
        end
        NEXT:    next_state = last_win ? DONE : START;
        DONE:    next_state = IDLE;
        ERROR:   if (clear_err) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Pulses are registered from the upcoming state so they line up with it
  always_comb begin
    load_enable_d = (next_state == LOAD);
    conv_start_d  = (next_state == START);
    tile_done_d   = (next_state == DONE);
    window_sel_d  = window_sel;
    tile_count_d  = tile_count;
    err_d         = err;
    if (next_state == IDLE || next_state == LOAD) begin
      window_sel_d = '0;
    end else if (state == NEXT && next_state == START) begin
      window_sel_d = window_sel + SEL_W'(1);
    end
    if (state == DONE && !abort) begin
      tile_count_d = tile_count + CNT_W'(1);
    end
    if (state == WAIT && next_state == ERROR) begin
      err_d = 1'b1;
    end else if (state == ERROR && next_state == IDLE) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      load_enable <= 1'b0;
      conv_start  <= 1'b0;
      tile_done   <= 1'b0;
      window_sel  <= '0;
      tile_count  <= '0;
      err         <= 1'b0;
    end else begin
      load_enable <= load_enable_d;
      conv_start  <= conv_start_d;
      tile_done   <= tile_done_d;
      window_sel  <= window_sel_d;
      tile_count  <= tile_count_d;
      err         <= err_d;
    end
  end

endmodule
